// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b110
   } alu_op_e;

   // Operation class the FSM requests; FUNCT defers to funct3/funct7
   typedef enum logic [1:0] {
      AOP_ADD, AOP_SUB, AOP_FUNCT
   } alu_class_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic alu_funct3_legal(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from requested op class and funct fields to ALU control.
module alu_decoder
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_CW = 3
) (
   input  alu_class_e          i_alu_class,
   input  logic [2:0]          i_funct3,
   input  logic                i_funct7b5,
   input  logic                i_op5,
   output logic [ALU_CW-1:0]   o_alu_cntrl
);

   alu_op_e w_op;

   always_comb begin
      w_op = ALU_ADD;
      case (i_alu_class)
         AOP_SUB:   w_op = ALU_SUB;
         AOP_FUNCT: begin
            case (i_funct3)
               // funct7b5 only selects SUB for R-type; addi ignores it
               3'b000:  w_op = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b110:  w_op = ALU_OR;
               3'b111:  w_op = ALU_AND;
               default: w_op = ALU_ADD;
            endcase
         end
         default:   w_op = ALU_ADD;
      endcase
   end

   assign o_alu_cntrl = ALU_CW'(w_op);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM. Define BRANCH_EXT_EN for bne/blt/bge/bltu/bgeu;
// without it only beq is accepted and other branches trap.
module mc_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int ALU_CW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic              funct7b5,
   input  logic              mem_ready,
   input  logic              zero,
   input  logic              negative,
   input  logic              carry,
   input  logic              over_flow,
   output logic              pc_write,
   output logic              adr_src,
   output logic              mem_write,
   output logic              ir_write,
   output logic              reg_write,
   output logic [1:0]        result_src,
   output logic [1:0]        alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        imm_src,
   output logic [ALU_CW-1:0] alu_cntrl,
   output logic              illegal
);

   state_e            r_state, w_next;
   alu_class_e        w_alu_class;
   logic              w_taken, w_branch_legal;
   logic [ALU_CW-1:0] w_alu_cntrl;

`ifdef BRANCH_EXT_EN
   assign w_branch_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
   always_comb begin
      case (funct3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = negative ^ over_flow;
         3'b101:  w_taken = ~(negative ^ over_flow);
         3'b110:  w_taken = ~carry;
         3'b111:  w_taken = carry;
         default: w_taken = 1'b0;
      endcase
   end
`else
   logic w_unused_flags;
   assign w_unused_flags = &{negative, carry, over_flow, 1'b0};
   assign w_branch_legal = (funct3 == 3'b000);
   assign w_taken        = zero;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_RTYPE:  w_next = alu_funct3_legal(funct3) ? S_EXECR : S_TRAP;
               OP_ITYPE:  w_next = alu_funct3_legal(funct3) ? S_EXECI : S_TRAP;
               OP_BRANCH: w_next = w_branch_legal ? S_BRANCH : S_TRAP;
               OP_JAL:    w_next = S_JAL;
               default:   w_next = S_TRAP;
            endcase
         end
         S_MEMADR:   w_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
         S_EXECR,
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_TRAP:     w_next = S_TRAP;
         default:    w_next = S_TRAP;
      endcase
   end

   // Reset forces every output low, overriding the Moore decode
   always_comb begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      imm_src     = IMM_I;
      illegal     = 1'b0;
      w_alu_class = AOP_ADD;
      if (!rst) begin
         case (opcode)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
         endcase
         case (r_state)
            S_FETCH: begin
               alu_src_b  = SRCB_FOUR;
               result_src = RES_ALU;
               pc_write   = mem_ready;
               ir_write   = mem_ready;
            end
            S_DECODE: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
               result_src = RES_MEM;
               reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            S_EXECR: begin
               alu_src_a   = SRCA_RS1;
               w_alu_class = AOP_FUNCT;
            end
            S_EXECI: begin
               alu_src_a   = SRCA_RS1;
               alu_src_b   = SRCB_IMM;
               w_alu_class = AOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
               alu_src_a   = SRCA_RS1;
               w_alu_class = AOP_SUB;
               pc_write    = w_taken;
            end
            S_JAL: begin
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_FOUR;
               pc_write  = 1'b1;
            end
            S_TRAP:     illegal = 1'b1;
            default:    illegal = 1'b1;
         endcase
      end
   end

   alu_decoder #(.ALU_CW(ALU_CW)) u_alu_dec (
      .i_alu_class (w_alu_class),
      .i_funct3    (funct3),
      .i_funct7b5  (funct7b5),
      .i_op5       (opcode[5]),
      .o_alu_cntrl (w_alu_cntrl)
   );

   assign alu_cntrl = w_alu_cntrl;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares. Extended-branch vectors need BRANCH_EXT_EN.
module tb_mc_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       mem_ready = 1'b0;
   logic       zero = 1'b0, negative = 1'b0, carry = 1'b0, over_flow = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_cntrl;

   mc_control_unit #(.ALU_CW(3)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .mem_ready(mem_ready), .zero(zero), .negative(negative), .carry(carry),
      .over_flow(over_flow), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_cntrl(alu_cntrl), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [16:0] exp_q[$];
   string       lbl_q[$];
   int          n_vec = 0;
   int          n_miss = 0;
   logic [1:0]  imm_e = 2'b00;

   // {pcw,adr,mw,irw,rw,res[2],a[2],b[2],imm[2],alu[3],ill}
   function automatic logic [16:0] E(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] rs, a, b, imm,
                                     input logic [2:0] alu, input logic ill);
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
   endfunction

   function automatic logic [16:0] xF(input logic r);   return E(r,0,0,r,0,2'd2,2'd0,2'd2,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xD();                return E(0,0,0,0,0,2'd0,2'd1,2'd1,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xMA();               return E(0,0,0,0,0,2'd0,2'd2,2'd1,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xMR();               return E(0,1,0,0,0,2'd0,2'd0,2'd0,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xMWB();              return E(0,0,0,0,1,2'd1,2'd0,2'd0,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xMW();               return E(0,1,1,0,0,2'd0,2'd0,2'd0,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xER(input logic [2:0] al); return E(0,0,0,0,0,2'd0,2'd2,2'd0,imm_e,al,0); endfunction
   function automatic logic [16:0] xEI(input logic [2:0] al); return E(0,0,0,0,0,2'd0,2'd2,2'd1,imm_e,al,0); endfunction
   function automatic logic [16:0] xWB();               return E(0,0,0,0,1,2'd0,2'd0,2'd0,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xBR(input logic t);  return E(t,0,0,0,0,2'd0,2'd2,2'd0,imm_e,3'd1,0); endfunction
   function automatic logic [16:0] xJ();                return E(1,0,0,0,0,2'd0,2'd1,2'd2,imm_e,3'd0,0); endfunction
   function automatic logic [16:0] xT();                return E(0,0,0,0,0,2'd0,2'd0,2'd0,imm_e,3'd0,1); endfunction
   function automatic logic [16:0] xZ();                return 17'd0; endfunction

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic [1:0] imm);
      opcode = op; funct3 = f3; funct7b5 = f7; imm_e = imm;
   endtask

   // One clock: drive inputs, queue expectation, advance to just after the edge
   task automatic cyc(input string lbl, input logic r, input logic rdy,
                      input logic [16:0] e);
      rst = r; mem_ready = rdy;
      exp_q.push_back(e);
      lbl_q.push_back(lbl);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [16:0] got, e;
         string       l;
         got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_cntrl, illegal};
         e = exp_q.pop_front();
         l = lbl_q.pop_front();
         n_vec++;
         if (got !== e) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b", l, got, e);
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      cyc("reset", 1, 1, xZ());

      set_instr(7'b0110011, 3'b000, 0, 2'b00);
      cyc("add.fetch", 0, 1, xF(1));
      cyc("add.decode", 0, 0, xD());
      cyc("add.execr", 0, 0, xER(3'b000));
      cyc("add.aluwb", 0, 0, xWB());

      set_instr(7'b0110011, 3'b000, 1, 2'b00);
      cyc("sub.fetch_wait", 0, 0, xF(0));
      cyc("sub.fetch", 0, 1, xF(1));
      cyc("sub.decode", 0, 1, xD());
      cyc("sub.execr", 0, 1, xER(3'b001));
      cyc("sub.aluwb", 0, 1, xWB());

      set_instr(7'b0010011, 3'b110, 1, 2'b00);
      cyc("ori.fetch", 0, 1, xF(1));
      cyc("ori.decode", 0, 1, xD());
      cyc("ori.execi", 0, 1, xEI(3'b110));
      cyc("ori.aluwb", 0, 1, xWB());

      set_instr(7'b0110011, 3'b111, 0, 2'b00);
      cyc("and.fetch", 0, 1, xF(1));
      cyc("and.decode", 0, 1, xD());
      cyc("and.execr", 0, 1, xER(3'b100));
      cyc("and.aluwb", 0, 1, xWB());

      set_instr(7'b0000011, 3'b010, 0, 2'b00);
      cyc("lw.fetch", 0, 1, xF(1));
      cyc("lw.decode", 0, 1, xD());
      cyc("lw.memadr", 0, 1, xMA());
      cyc("lw.memread0", 0, 0, xMR());
      cyc("lw.memread1", 0, 0, xMR());
      cyc("lw.memread2", 0, 1, xMR());
      cyc("lw.memwb", 0, 0, xMWB());

      set_instr(7'b0100011, 3'b010, 0, 2'b01);
      cyc("sw.fetch", 0, 1, xF(1));
      cyc("sw.decode", 0, 1, xD());
      cyc("sw.memadr", 0, 1, xMA());
      cyc("sw.memwrite0", 0, 0, xMW());
      cyc("sw.memwrite1", 0, 1, xMW());

      set_instr(7'b1100011, 3'b000, 0, 2'b10);
      zero = 1;
      cyc("beq_t.fetch", 0, 1, xF(1));
      cyc("beq_t.decode", 0, 1, xD());
      cyc("beq_t.branch", 0, 1, xBR(1));
      zero = 0;
      cyc("beq_n.fetch", 0, 1, xF(1));
      cyc("beq_n.decode", 0, 1, xD());
      cyc("beq_n.branch", 0, 1, xBR(0));

`ifdef BRANCH_EXT_EN
      set_instr(7'b1100011, 3'b110, 0, 2'b10);
      carry = 0;
      cyc("bltu.fetch", 0, 1, xF(1));
      cyc("bltu.decode", 0, 1, xD());
      cyc("bltu.branch", 0, 1, xBR(1));
      set_instr(7'b1100011, 3'b100, 0, 2'b10);
      negative = 1; over_flow = 1;
      cyc("blt.fetch", 0, 1, xF(1));
      cyc("blt.decode", 0, 1, xD());
      cyc("blt.branch", 0, 1, xBR(0));
      negative = 0; over_flow = 0;
`else
      set_instr(7'b1100011, 3'b001, 0, 2'b10);
      cyc("bne.fetch", 0, 1, xF(1));
      cyc("bne.decode", 0, 1, xD());
      cyc("bne.trap", 0, 1, xT());
      cyc("bne.reset", 1, 1, xZ());
`endif

      set_instr(7'b1101111, 3'b000, 0, 2'b11);
      cyc("jal.fetch", 0, 1, xF(1));
      cyc("jal.decode", 0, 1, xD());
      cyc("jal.jal", 0, 1, xJ());
      cyc("jal.aluwb", 0, 1, xWB());

      set_instr(7'b0100011, 3'b010, 0, 2'b01);
      cyc("sw_abort.fetch", 0, 1, xF(1));
      cyc("sw_abort.decode", 0, 1, xD());
      cyc("sw_abort.memadr", 0, 1, xMA());
      cyc("sw_abort.memwrite", 0, 0, xMW());
      cyc("sw_abort.reset", 1, 0, xZ());
      cyc("sw_abort.fetch_after", 0, 0, xF(0));

      set_instr(7'b0110011, 3'b001, 0, 2'b00);
      cyc("badf3.fetch", 0, 1, xF(1));
      cyc("badf3.decode", 0, 1, xD());
      cyc("badf3.trap", 0, 1, xT());
      cyc("badf3.reset", 1, 1, xZ());

      set_instr(7'b0000000, 3'b000, 0, 2'b00);
      cyc("op0.fetch", 0, 1, xF(1));
      cyc("op0.decode", 0, 1, xD());
      for (int i = 0; i < 10; i++) cyc($sformatf("op0.trap%0d", i), 0, 1, xT());
      cyc("op0.reset", 1, 1, xZ());
      set_instr(7'b0110011, 3'b000, 0, 2'b00);
      cyc("op0.fetch_after", 0, 0, xF(0));
      cyc("op0.fetch_go", 0, 1, xF(1));

      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
